sumador_operand_loader: RTL and testbench

- Upstream operand stage for the `SUMADORQ22` sign-magnitude adder.
- Accepts two 5-bit sign-magnitude operands, one per transfer, over a valid/ready stream. Drives them to the adder and holds them stable for the adder's pipeline latency.
- Captures the adder's 6-bit result and presents it downstream with its own valid/ready handshake.
- Turns the adder's free-running pipeline into a transaction-level unit: one operand pair in, one result out.

---
 rtl/sumador_pkg.sv | 21 ++
 rtl/sumador_lat_counter.sv | 32 +++
 rtl/sumador_operand_loader.sv | 88 ++++++++
 tb/tb_sumador_operand_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// Shared types and helpers for the SUMADORQ22 operand loader.
// SUMADOR_NEGZERO_CANON_EN selects negative-zero canonicalisation of stored operands.
package sumador_pkg;

  localparam int SM_W  = 5;
  localparam int RES_W = 6;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_GOT_A = 2'd1,
    LDR_WAIT  = 2'd2,
    LDR_DONE  = 2'd3
  } loader_state_t;

  // Sign-magnitude negative zero (sign set, magnitude 0) maps to positive zero.
  function automatic logic [SM_W-1:0] canon_zero(input logic [SM_W-1:0] op);
    if (op[SM_W-2:0] == '0) return '0;
    return op;
  endfunction

endpackage

// File: rtl/sumador_lat_counter.sv
// Loadable down-counter that times the adder pipeline; zero flag marks the capture edge.
module sumador_lat_counter #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LATENCY);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sumador_operand_loader.sv
// Operand stage for the SUMADORQ22 adder: two operands in, one captured result out.
// Optional SUMADOR_NEGZERO_CANON_EN stores negative-zero operands as positive zero.
module sumador_operand_loader
  import sumador_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SM_W-1:0]  in_data,
  output logic [SM_W-1:0]  op_a,
  output logic [SM_W-1:0]  op_b,
  input  logic [RES_W-1:0] sum_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data
);

  localparam logic [1:0] IDLE  = LDR_IDLE;
  localparam logic [1:0] GOT_A = LDR_GOT_A;
  localparam logic [1:0] WAIT  = LDR_WAIT;
  localparam logic [1:0] DONE  = LDR_DONE;

  logic [1:0]      state;
  logic [SM_W-1:0] operand;
  logic            cnt_zero;
  logic            load_b;

  always_comb begin
`ifdef SUMADOR_NEGZERO_CANON_EN
    operand = canon_zero(in_data);
`else
    operand = in_data;
`endif
  end

  // NOTE: in_ready is a pure state decode, assigned on every path so no latch is inferred.
  assign in_ready = (state == IDLE) || (state == GOT_A);
  assign load_b   = (state == GOT_A) && in_valid && !flush;

  sumador_lat_counter #(.LATENCY(LATENCY)) u_lat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (load_b),
    .en    (state == WAIT),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (flush) begin
      // Abort wins over any handshake; operands and last result are kept.
      state     <= IDLE;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a  <= operand;
          state <= GOT_A;
        end
        GOT_A: if (in_valid) begin
          op_b  <= operand;
          state <= WAIT;
        end
        WAIT: if (cnt_zero) begin
          res_data  <= sum_in;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_operand_loader.sv
// Directed bench for sumador_operand_loader with a behavioural SUMADORQ22 pipeline model.
module tb_sumador_operand_loader;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic [4:0] op_a;
  logic [4:0] op_b;
  logic [5:0] sum_in;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_data;

  int n_checks = 0;
  int n_fail   = 0;

  sumador_operand_loader #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op_a      (op_a),
    .op_b      (op_b),
    .sum_in    (sum_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  // Stand-in adder: sign-magnitude sum through LAT register stages.
  function automatic logic [5:0] sm_add(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] ma, mb;
    ma = {1'b0, a[3:0]};
    mb = {1'b0, b[3:0]};
    if (a[4] == b[4]) return {a[4], ma + mb};
    if (ma > mb)      return {a[4], ma - mb};
    if (mb > ma)      return {b[4], mb - ma};
    return 6'd0;
  endfunction

  logic [5:0] pipe [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= sm_add(op_a, op_b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign sum_in = pipe[LAT-1];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand until accepted, bounded.
  task automatic send(input logic [4:0] d, input string tag);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_accept"}, {7'd0, done}, 8'd1);
  endtask

  task automatic wait_res(input string tag);
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    check({tag, "_timeout"}, {7'd0, res_valid}, 8'd1);
  endtask

  logic [4:0] negzero_exp;
  logic       saw_valid;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    #2;
    check("rst_in_ready", {7'd0, in_ready}, 8'd1);
    check("rst_op_a", {3'd0, op_a}, 8'd0);
    check("rst_op_b", {3'd0, op_b}, 8'd0);
    check("rst_res_valid", {7'd0, res_valid}, 8'd0);
    check("rst_res_data", {2'd0, res_data}, 8'd0);
    #10 rst = 1'b0;
    tick();

    // Basic transaction: 3 + 5 = 8, result exactly 5 edges after B accept.
    res_ready = 1'b1;
    send(5'b00011, "basic_a");
    send(5'b00101, "basic_b");
    check("basic_op_a", {3'd0, op_a}, 8'h03);
    check("basic_op_b", {3'd0, op_b}, 8'h05);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("basic_valid_edge%0d", k), {7'd0, res_valid}, (k == 5) ? 8'd1 : 8'd0);
    end
    check("basic_res_data", {2'd0, res_data}, 8'b0000_1000);
    tick();
    check("basic_valid_one_cycle", {7'd0, res_valid}, 8'd0);
    check("basic_in_ready_after", {7'd0, in_ready}, 8'd1);
    check("basic_res_data_held", {2'd0, res_data}, 8'b0000_1000);

    // Zero operand: 0 + (-6) = -6.
    send(5'b00000, "zero_a");
    send(5'b10110, "zero_b");
    wait_res("zero");
    check("zero_res_data", {2'd0, res_data}, 8'b0010_0110);
    tick();
    tick();
    check("zero_op_a_held", {3'd0, op_a}, 8'h00);
    check("zero_op_b_held", {3'd0, op_b}, 8'b0001_0110);

    // Backpressure: 7 + (-2) = 5, held for 10 cycles while a third operand is offered.
    res_ready = 1'b0;
    send(5'b00111, "bp_a");
    send(5'b10010, "bp_b");
    wait_res("bp");
    in_valid = 1'b1;
    in_data  = 5'b01111;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_res_valid", {7'd0, res_valid}, 8'd1);
      check("bp_res_data", {2'd0, res_data}, 8'b0000_0101);
      check("bp_in_ready", {7'd0, in_ready}, 8'd0);
      check("bp_op_a", {3'd0, op_a}, 8'b0000_0111);
      check("bp_op_b", {3'd0, op_b}, 8'b0001_0010);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    check("bp_release_valid", {7'd0, res_valid}, 8'd0);
    check("bp_release_ready", {7'd0, in_ready}, 8'd1);

    // Flush in WAIT with two counts left, operand offered at the same time.
    send(5'b00001, "fl_a");
    send(5'b00010, "fl_b");
    tick();
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'b01010;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_idle", {7'd0, in_ready}, 8'd1);
    check("fl_res_valid", {7'd0, res_valid}, 8'd0);
    check("fl_op_a_kept", {3'd0, op_a}, 8'h01);
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      saw_valid |= res_valid;
    end
    check("fl_no_valid", {7'd0, saw_valid}, 8'd0);
    send(5'b01010, "fl_next_a");
    check("fl_next_op_a", {3'd0, op_a}, 8'b0000_1010);
    check("fl_next_op_b", {3'd0, op_b}, 8'h02);

    // Reset while a result is pending.
    res_ready = 1'b0;
    send(5'b00100, "rd_b");
    wait_res("rd");
    #2 rst = 1'b1;
    #1;
    check("rd_in_ready", {7'd0, in_ready}, 8'd1);
    check("rd_op_a", {3'd0, op_a}, 8'd0);
    check("rd_op_b", {3'd0, op_b}, 8'd0);
    check("rd_res_valid", {7'd0, res_valid}, 8'd0);
    check("rd_res_data", {2'd0, res_data}, 8'd0);
    #3 rst = 1'b0;
    tick();

    // Negative-zero operand storage.
`ifdef SUMADOR_NEGZERO_CANON_EN
    negzero_exp = 5'b00000;
`else
    negzero_exp = 5'b10000;
`endif
    send(5'b10000, "nz_a");
    check("nz_op_a", {3'd0, op_a}, {3'd0, negzero_exp});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
